// File: rtl/risc16_pkg.sv
// Shared types and constants for the RISC16 instruction fetch path.
// Fetch FSM encoding, the FIFO entry layout and PC helpers live here.
package risc16_pkg;

  localparam int XLEN       = 16;
  localparam int INSTR_W    = 16;
  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_W     = INSTR_W + XLEN;

  localparam logic [XLEN-1:0] PC_INC           = 16'd2;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fetch_entry_t;

  // Instructions are halfword aligned, so bit 0 of any fetch address is dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/risc16_fetch_fifo.sv
// Two-entry instruction buffer between the fetch FSM and the decode stage.
// Head entry is visible combinationally; flush discards everything at once.
module risc16_fetch_fifo
  import risc16_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [FIFO_W-1:0] i_wdata,
  input  logic              i_pop,
  input  logic              i_flush,
  output logic [FIFO_W-1:0] o_rdata,
  output logic [1:0]        o_count
);

  logic [FIFO_W-1:0] r_mem [FIFO_DEPTH];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic              w_pop_ok;
  logic              w_push_ok;

  assign w_pop_ok  = i_pop && (r_count != 2'd0);
  assign w_push_ok = i_push && ((r_count != 2'd2) || w_pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      // A same-cycle pop is subsumed: the flush empties the buffer either way.
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/risc16_fetch_unit.sv
// Instruction fetch unit: one outstanding memory request, two-entry buffer,
// redirect flushes the buffer and drops any in-flight response.
module risc16_fetch_unit
  import risc16_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [XLEN-1:0]    instr_pc,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [XLEN-1:0]    redirect_pc
);

  localparam logic [XLEN-1:0] RESET_PC_A = {RESET_PC[XLEN-1:1], 1'b0};

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_fetch_pc;
  logic            r_imem_req;
  logic [XLEN-1:0] r_imem_addr;

  logic [XLEN-1:0] w_redirect_pc;
  logic [XLEN-1:0] w_pc_inc;
  logic            w_pop;
  logic            w_push;
  logic            w_refetch;
  logic [1:0]      w_count;
  fetch_entry_t    w_push_entry;
  fetch_entry_t    w_head;
  logic [FIFO_W-1:0] w_fifo_rdata;

  assign w_redirect_pc = align_pc(redirect_pc);
  assign w_pc_inc      = r_fetch_pc + PC_INC;
  assign w_pop         = instr_valid && instr_ready;
  assign w_push        = (r_state == ST_WAIT) && imem_ack && !redirect;

  // Back-to-back refetch is safe when the entry being pushed will not fill the
  // buffer: either it is empty now, or its current head retires this cycle.
  assign w_refetch = (w_count == 2'd0) || w_pop;

  assign w_push_entry.instr = imem_rdata;
  assign w_push_entry.pc    = r_imem_addr;

  risc16_fetch_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (w_push_entry),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .o_rdata (w_fifo_rdata),
    .o_count (w_count)
  );

  assign w_head = w_fifo_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_fetch_pc  <= RESET_PC_A;
      r_imem_req  <= 1'b0;
      r_imem_addr <= RESET_PC_A;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (redirect) begin
            r_fetch_pc  <= w_redirect_pc;
            r_imem_addr <= w_redirect_pc;
            r_imem_req  <= 1'b1;
            r_state     <= ST_WAIT;
          end else if (w_count != 2'd2) begin
            r_imem_addr <= r_fetch_pc;
            r_imem_req  <= 1'b1;
            r_state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (redirect) begin
            r_fetch_pc <= w_redirect_pc;
            if (imem_ack) begin
              r_imem_req <= 1'b0;
              r_state    <= ST_IDLE;
            end else begin
              // Request must stay stable until acked; its data will be thrown away.
              r_state <= ST_DROP;
            end
          end else if (imem_ack) begin
            r_fetch_pc <= w_pc_inc;
            if (w_refetch) begin
              r_imem_addr <= w_pc_inc;
            end else begin
              r_imem_req <= 1'b0;
              r_state    <= ST_IDLE;
            end
          end
        end
        ST_DROP: begin
          if (redirect) begin
            r_fetch_pc <= w_redirect_pc;
          end
          if (imem_ack) begin
            r_imem_req <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_imem_req <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_imem_addr;
  assign instr_valid = (w_count != 2'd0);
  assign instr       = w_head.instr;
  assign instr_pc    = w_head.pc;

endmodule

// File: tb/tb_risc16_fetch_unit.sv
// Scoreboard bench for risc16_fetch_unit: a memory model answers requests,
// a monitor compares every consumed instruction against the expected stream.
module tb_risc16_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [15:0] redirect_pc;

  int checks   = 0;
  int errors   = 0;
  int pops     = 0;
  int mem_wait = 0;
  int wait_cnt = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  risc16_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_stream(input logic [15:0] start);
    logic [15:0] p;
    p = start;
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back(p);
      p = p + 16'd2;
    end
  endtask

  task automatic do_redirect(input logic [15:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    tick(1);
    load_stream(pc);
    check("valid_after_redirect", 16'(instr_valid), 16'd0);
    redirect = 1'b0;
    $display("redirect to %h", pc);
  endtask

  task automatic wait_req(input logic val, input string name);
    int n;
    n = 0;
    while (imem_req !== val && n < 50) begin
      tick(1);
      n++;
    end
    check(name, 16'(imem_req), 16'(val));
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (instr_valid !== 1'b1 && n < 50) begin
      tick(1);
      n++;
    end
    check(name, 16'(instr_valid), 16'd1);
  endtask

  // Memory model: acknowledges after mem_wait idle cycles of a held request.
  always @(negedge clk) begin
    if (imem_req === 1'b1) begin
      if (wait_cnt >= mem_wait) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        wait_cnt   = 0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 16'hDEAD;
        wait_cnt++;
      end
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 16'hDEAD;
      wait_cnt   = 0;
    end
  end

  // Monitor: every consumed instruction must be the next expected one.
  always @(negedge clk) begin
    logic [15:0] e;
    if (rst_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected actual pc=%h required none", instr_pc);
      end else begin
        e = exp_q.pop_front();
        $display("pop pc=%h instr=%h expected pc=%h", instr_pc, instr, e);
        check("instr_pc", instr_pc, e);
        check("instr", instr, mem_word(e));
        pops++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mark;
    int n;
    logic [15:0] old_addr;

    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    instr_ready = 1'b1;
    imem_ack    = 1'b0;
    imem_rdata  = 16'hDEAD;
    tick(3);
    check("rst_req", 16'(imem_req), 16'd0);
    check("rst_addr", imem_addr, 16'h0000);
    check("rst_valid", 16'(instr_valid), 16'd0);
    check("rst_instr", instr, 16'h0000);
    check("rst_instr_pc", instr_pc, 16'h0000);

    // Zero-wait streaming from reset.
    load_stream(16'h0000);
    rst_n = 1'b1;
    tick(1);
    check("first_req", 16'(imem_req), 16'd1);
    check("first_addr", imem_addr, 16'h0000);
    check("first_valid", 16'(instr_valid), 16'd0);
    tick(1);
    check("addr_c2", imem_addr, 16'h0002);
    check("valid_c2", 16'(instr_valid), 16'd1);
    check("pc_c2", instr_pc, 16'h0000);
    tick(1);
    check("addr_c3", imem_addr, 16'h0004);
    check("pc_c3", instr_pc, 16'h0002);
    tick(1);
    check("addr_c4", imem_addr, 16'h0006);
    check("pc_c4", instr_pc, 16'h0004);

    // Backpressure: buffer fills to two entries and fetching stops.
    instr_ready = 1'b0;
    tick(1);
    for (int i = 0; i < 6; i++) begin
      check("stall_req", 16'(imem_req), 16'd0);
      check("stall_valid", 16'(instr_valid), 16'd1);
      check("stall_pc", instr_pc, 16'h0004);
      check("stall_instr", instr, mem_word(16'h0004));
      tick(1);
    end
    instr_ready = 1'b1;
    tick(12);
    check("pops_stream", 16'(pops >= 8), 16'd1);

    // Redirect on the second wait cycle of a slow request.
    mem_wait = 3;
    check("req_before_slow", 16'(imem_req), 16'd1);
    tick(1);
    old_addr = imem_addr;
    do_redirect(16'h0100);
    check("drop_req_held", 16'(imem_req), 16'd1);
    check("drop_addr_held", imem_addr, old_addr);
    wait_req(1'b0, "drop_released");
    wait_req(1'b1, "req_after_drop");
    check("addr_after_drop", imem_addr, 16'h0100);
    wait_valid("valid_after_drop");
    check("first_pc_after_drop", instr_pc, 16'h0100);

    // Redirect coincident with the ack of address 0x0008.
    do_redirect(16'h0000);
    n = 0;
    while (!(imem_req === 1'b1 && imem_addr === 16'h0008) && n < 100) begin
      tick(1);
      n++;
    end
    check("req_addr8_seen", imem_addr, 16'h0008);
    tick(3);
    do_redirect(16'h0040);
    check("idle_after_ack_redirect", 16'(imem_req), 16'd0);
    tick(1);
    check("req_0040", 16'(imem_req), 16'd1);
    check("addr_0040", imem_addr, 16'h0040);
    wait_valid("valid_0040");
    check("first_pc_0040", instr_pc, 16'h0040);

    // Wrap of the fetch address past 0xFFFE.
    mem_wait = 0;
    mark = pops;
    do_redirect(16'hFFFC);
    wait_valid("valid_fffc");
    check("first_pc_fffc", instr_pc, 16'hFFFC);
    tick(10);
    check("pops_wrap", 16'(pops - mark >= 4), 16'd1);

    // Reset with a request outstanding and an entry buffered.
    instr_ready = 1'b0;
    mem_wait    = 4;
    n = 0;
    while (!(imem_req === 1'b1 && instr_valid === 1'b1) && n < 40) begin
      tick(1);
      n++;
    end
    check("pre_reset_busy", 16'(imem_req && instr_valid), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req", 16'(imem_req), 16'd0);
    check("async_rst_addr", imem_addr, 16'h0000);
    check("async_rst_valid", 16'(instr_valid), 16'd0);
    check("async_rst_instr", instr, 16'h0000);
    check("async_rst_pc", instr_pc, 16'h0000);
    load_stream(16'h0000);
    mem_wait    = 0;
    instr_ready = 1'b1;
    tick(2);
    rst_n = 1'b1;
    mark  = pops;
    tick(1);
    check("rerst_req", 16'(imem_req), 16'd1);
    check("rerst_addr", imem_addr, 16'h0000);
    wait_valid("rerst_valid");
    check("rerst_first_pc", instr_pc, 16'h0000);
    tick(8);
    check("pops_after_reset", 16'(pops - mark >= 6), 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
